// File: rtl/md_if.sv
// Multiply/divide unit bus: operation launch, HI/LO move strobes and results.
interface md_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_wr;
    logic             lo_wr;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_wr, lo_wr, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_wr, lo_wr, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fixed at the end.
module md_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    md_if.slave  bus
);
    localparam int unsigned CW = 5;
    localparam int unsigned DW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] mag_a, mag_b, raw_a;
    logic             neg_a, neg_b;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, shreg;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    logic             sgn_in;
    logic [WIDTH-1:0] mag_a_in, mag_b_in;
    logic [WIDTH:0]   mul_sum, rem_s;
    logic             div_ok;
    logic [WIDTH-1:0] acc_nxt, shreg_nxt;
    logic [DW-1:0]    product, prod_fix;
    logic [WIDTH-1:0] hi_fix, lo_fix;

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Operand magnitudes at launch; unsigned ops pass raw values through
    assign sgn_in   = bus.op[0];
    assign mag_a_in = (sgn_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b_in = (sgn_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration: multiply shifts {acc,multiplier} right, divide shifts {rem,quot} left
    always_comb begin
        mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, mag_a} : {(WIDTH + 1){1'b0}});
        rem_s     = {acc, shreg[WIDTH-1]};
        div_ok    = (rem_s >= {1'b0, mag_b});
        acc_nxt   = mul_sum[WIDTH:1];
        shreg_nxt = {mul_sum[0], shreg[WIDTH-1:1]};
        if (op_q[1]) begin
            acc_nxt   = div_ok ? WIDTH'(rem_s - {1'b0, mag_b}) : rem_s[WIDTH-1:0];
            shreg_nxt = {shreg[WIDTH-2:0], div_ok};
        end
    end

    // Final sign correction; signed flags are only ever set for MULT/DIV
    always_comb begin
        product  = {acc, shreg};
        prod_fix = (neg_a ^ neg_b) ? -product : product;
        hi_fix   = prod_fix[DW-1:WIDTH];
        lo_fix   = prod_fix[WIDTH-1:0];
        if (op_q[1]) begin
            if (mag_b == '0) begin
                hi_fix = raw_a;
                lo_fix = '1;
            end else begin
                hi_fix = neg_a ? -acc : acc;
                lo_fix = (neg_a ^ neg_b) ? -shreg : shreg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            raw_a  <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            shreg  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q  <= bus.op;
                        mag_a <= mag_a_in;
                        mag_b <= mag_b_in;
                        raw_a <= bus.a;
                        neg_a <= sgn_in & bus.a[WIDTH-1];
                        neg_b <= sgn_in & bus.b[WIDTH-1];
                        cnt   <= '0;
                        acc   <= '0;
                        shreg <= bus.op[1] ? mag_a_in : mag_b_in;
                    end else begin
                        if (bus.hi_wr) hi_q <= bus.wdata;
                        if (bus.lo_wr) lo_q <= bus.wdata;
                    end
                end
                CALC: begin
                    cnt   <= cnt + CW'(1);
                    acc   <= acc_nxt;
                    shreg <= shreg_nxt;
                end
                FIX: begin
                    hi_q   <= hi_fix;
                    lo_q   <= lo_fix;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  launch operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port a  input  32  multiplicand / dividend (GPR rs).
REQ-007 SHALL have port b  input  32  multiplier / divisor (GPR rt).
REQ-008 SHALL have port hi_wr  input  1  MTHI write strobe.
REQ-009 SHALL have port lo_wr  input  1  MTLO write strobe.
REQ-010 SHALL have port wdata  input  32  MTHI/MTLO data.
REQ-011 SHALL have port busy  output  1  operation in progress; the main FSM stalls MFHI/MFLO/MTHI/MTLO/start while high.
REQ-012 SHALL have port done  output  1  one-cycle pulse, HI/LO just updated.
REQ-013 SHALL have port hi  output  32  HI register (MFHI source).
REQ-014 SHALL have port lo  output  32  LO register (MFLO source).

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FIX; busy = (state != IDLE), combinational from state.
REQ-016 SHALL, in IDLE with start=1 at edge E0: latch op; latch |a|, |b| (two's-complement magnitude for MULT/DIV, raw for MULTU/DIVU); latch sign flags; clear 5-bit iteration counter and accumulator; go to CALC.
REQ-017 SHALL perform one iteration per edge in CALC (edges E1..E32); counter increments each iteration; CALC->FIX at the edge where counter==31.
REQ-018 SHALL multiply by radix-2 shift-add: per iteration, if multiplier LSB=1 add multiplicand into upper accumulator half (33-bit sum, carry kept), then shift 64-bit {acc,multiplier} right by 1.
REQ-019 SHALL divide by restoring division: per iteration shift {rem,quot} left 1, trial-subtract divisor from 33-bit rem; if non-negative keep difference and set quot LSB=1, else restore and set LSB=0.
REQ-020 SHALL, at edge E33 (FIX->IDLE): apply sign correction, write hi/lo, assert done for exactly the following cycle.
REQ-021 SHALL sign-correct MULT by negating the 64-bit product when sign(a)!=sign(b); HI=product[63:32], LO=product[31:0].
REQ-022 SHALL sign-correct DIV: quotient negated when sign(a)!=sign(b); remainder takes sign of a; LO=quotient, HI=remainder.
REQ-023 SHALL, for divide by zero (b==0, DIV or DIVU): LO=32'hFFFFFFFF, HI=a as latched at E0 (raw, not magnitude); still 33 busy cycles.
REQ-024 SHALL yield DIV 32'h80000000 / 32'hFFFFFFFF as LO=32'h80000000, HI=0 with no exception.
REQ-025 SHALL ignore start, hi_wr, lo_wr while busy=1; hi/lo remain stable from E0 through E33.
REQ-026 SHALL, in IDLE: hi_wr writes wdata to hi, lo_wr writes wdata to lo at the edge; both may assert together.
REQ-027 SHALL give start precedence over hi_wr/lo_wr in the same IDLE cycle; the writes are dropped.
REQ-028 SHALL make latency fixed at 33 busy cycles for every op; back-to-back start accepted in the cycle done=1.

Reset
REQ-029 SHALL on rst=0, asynchronously and regardless of state (including mid-CALC): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, operand latches=0.
REQ-030 SHALL not resume or complete an aborted operation after rst returns high.

Verification
REQ-031 SHALL pass: MULTU a=32'hFFFFFFFF b=32'hFFFFFFFF -> after 33 busy cycles hi=32'hFFFFFFFE, lo=32'h00000001, done one cycle.
REQ-032 SHALL pass: MULT a=-3 b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; DIV a=-7 b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-033 SHALL pass: DIVU a=100 b=0 -> lo=32'hFFFFFFFF, hi=100; DIV a=32'h80000000 b=-1 -> lo=32'h80000000, hi=0.
REQ-034 SHALL pass: hi_wr=1 wdata=32'h1234 during busy -> hi unchanged; in IDLE -> hi=32'h1234 next cycle; start+lo_wr same cycle -> lo_wr dropped.
REQ-035 SHALL pass: rst=0 pulse at CALC iteration 10 -> busy=0, done=0, hi=lo=0 immediately; no done afterwards.
REQ-036 SHALL pass: start held high continuously -> new operation begins the cycle done=1, done pulses every 34 cycles.
